banded_matvec_engine: RTL and testbench



---
 rtl/banded_matvec_pkg.sv | 30 +++
 rtl/banded_row_unit.sv | 76 +++++++
 rtl/banded_matvec_engine.sv | 115 +++++++++++
 tb/tb_banded_matvec_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banded_matvec_pkg.sv
// Shared constants and elaboration-time helpers for the banded matrix-by-vector engine.
package banded_matvec_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_SUM  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that stays at least one bit even for a single group.
  function automatic int idx_width(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

  // Full-precision width: one product plus growth for summing BAND of them.
  function automatic int acc_width(input int elem_w, input int band);
    return 2 * elem_w + clog2(band) + 1;
  endfunction

endpackage

// File: rtl/banded_row_unit.sv
// One row lane: masked band products registered in MUL, then summed and registered in SUM.
module banded_row_unit
  import banded_matvec_pkg::*;
#(
  parameter int N_EQN     = 5,
  parameter int BAND      = 3,
  parameter int NUM_UNITS = 4,
  parameter int ELEM_W    = 16,
  parameter int ACC_W     = 35,
  parameter int G_W       = 1,
  parameter int LANE      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_mul_en,
  input  logic                          i_sum_en,
  input  logic [G_W-1:0]                i_g,
  input  logic [N_EQN*BAND*ELEM_W-1:0]  i_mat,
  input  logic [N_EQN*ELEM_W-1:0]       i_vec,
  output logic [ACC_W-1:0]              o_sum
);

  localparam int H  = (BAND - 1) / 2;
  localparam int PW = 2 * ELEM_W;

  logic signed [ACC_W-1:0] w_prod [BAND];
  logic signed [ACC_W-1:0] r_prod [BAND];
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_sum;

  // Out-of-range rows and columns select nothing, so their operands stay zero.
  always_comb begin
    int                       row;
    int                       col;
    logic signed [ELEM_W-1:0] w_a;
    logic signed [ELEM_W-1:0] w_b;
    logic signed [PW-1:0]     w_p;
    row = int'(i_g) * NUM_UNITS + LANE;
    for (int c = 0; c < BAND; c++) begin
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      col = row + c - H;
      w_a = '0;
      w_b = '0;
      if (row < N_EQN && col >= 0 && col < N_EQN) begin
        for (int j = 0; j < N_EQN; j++) begin
          if (j == row) w_a = i_mat[(j*BAND+c)*ELEM_W +: ELEM_W];
          if (j == col) w_b = i_vec[j*ELEM_W +: ELEM_W];
        end
      end
      w_p       = w_a * w_b;
      w_prod[c] = {{(ACC_W-PW){w_p[PW-1]}}, w_p};
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < BAND; c++) w_sum = w_sum + r_prod[c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the product array is small pipeline state, so it is reset like any register.
      for (int c = 0; c < BAND; c++) r_prod[c] <= '0;
      r_sum <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (i_mul_en) begin
        for (int c = 0; c < BAND; c++) r_prod[c] <= w_prod[c];
      end
      if (i_sum_en) r_sum <= w_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/banded_matvec_engine.sv
// Banded y = A*x engine: latches operands, runs NUM_UNITS lanes per group, streams groups out.
module banded_matvec_engine
  import banded_matvec_pkg::*;
#(
  parameter int N_EQN     = 5,
  parameter int BAND      = 3,
  parameter int NUM_UNITS = 4,
  parameter int ELEM_W    = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [N_EQN*BAND*ELEM_W-1:0]                 mat,
  input  logic [N_EQN*ELEM_W-1:0]                      vec,
  output logic [NUM_UNITS*acc_width(ELEM_W,BAND)-1:0]  out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [NUM_UNITS-1:0]                         out_mask,
  output logic                                         out_last,
  output logic                                         busy,
  output logic                                         done
);

  localparam int ACC_W = acc_width(ELEM_W, BAND);
  localparam int G     = ceil_div(N_EQN, NUM_UNITS);
  localparam int G_W   = idx_width(G);

  logic [1:0]                    r_state;
  logic [G_W-1:0]                r_g;
  logic [N_EQN*BAND*ELEM_W-1:0]  r_mat;
  logic [N_EQN*ELEM_W-1:0]       r_vec;
  logic                          r_valid;
  logic                          r_last;
  logic                          r_done;
  logic [NUM_UNITS-1:0]          r_mask;
  logic [NUM_UNITS-1:0]          w_mask;
  logic                          w_hs;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_UNITS; k++) w_mask[k] = (int'(r_g) * NUM_UNITS + k < N_EQN);
  end

  assign w_hs = r_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_mat   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mat   <= mat;
            r_vec   <= vec;
            r_g     <= '0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: r_state <= ST_SUM;
        ST_SUM: begin
          r_valid <= 1'b1;
          r_mask  <= w_mask;
          r_last  <= (r_g == G_W'(G - 1));
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          // Payload holds until the consumer takes it; done marks the final acceptance.
          if (w_hs) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_g     <= r_g + G_W'(1);
              r_state <= ST_MUL;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
    banded_row_unit #(
      .N_EQN(N_EQN), .BAND(BAND), .NUM_UNITS(NUM_UNITS), .ELEM_W(ELEM_W),
      .ACC_W(ACC_W), .G_W(G_W), .LANE(k)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_mul_en (r_state == ST_MUL),
      .i_sum_en (r_state == ST_SUM),
      .i_g      (r_g),
      .i_mat    (r_mat),
      .i_vec    (r_vec),
      .o_sum    (out_data[k*ACC_W +: ACC_W])
    );
  end

  assign out_valid = r_valid;
  assign out_mask  = r_mask;
  assign out_last  = r_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_banded_matvec_engine.sv
// Directed bench: a plain-arithmetic y = A*x model scores every beat of a 5-row and an 8-row engine.
module tb_banded_matvec_engine;
  import banded_matvec_pkg::*;

  localparam int W     = 16;
  localparam int BND   = 3;
  localparam int U     = 4;
  localparam int ACC_W = acc_width(W, BND);
  localparam int DW    = U * ACC_W;
  localparam int NA    = 5;
  localparam int NB    = 8;
  localparam int GA    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start, b_start;
  logic [NA*BND*W-1:0] a_mat;
  logic [NA*W-1:0]     a_vec;
  logic [DW-1:0]       a_data;
  logic                a_valid, a_ready, a_last, a_busy, a_done;
  logic [U-1:0]        a_mask;
  logic [NB*BND*W-1:0] b_mat;
  logic [NB*W-1:0]     b_vec;
  logic [DW-1:0]       b_data;
  logic                b_valid, b_ready, b_last, b_busy, b_done;
  logic [U-1:0]        b_mask;

  banded_matvec_engine #(.N_EQN(NA), .BAND(BND), .NUM_UNITS(U), .ELEM_W(W)) dut_a (
    .clk(clk), .reset(reset), .start(start), .mat(a_mat), .vec(a_vec),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready), .out_mask(a_mask),
    .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  banded_matvec_engine #(.N_EQN(NB), .BAND(BND), .NUM_UNITS(U), .ELEM_W(W)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .mat(b_mat), .vec(b_vec),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .out_mask(b_mask),
    .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_arr [NB][BND];
  int x_arr [NB];

  function automatic longint model_y(input int n, input int r);
    longint s;
    s = 0;
    for (int c = 0; c < BND; c++) begin
      int col;
      col = r + c - 1;
      if (col >= 0 && col < n) s += longint'(m_arr[r][c]) * longint'(x_arr[col]);
    end
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] acc(input longint v);
    logic [63:0] t;
    t = v;
    return t[ACC_W-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_data(input int n, input int beat);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < U; k++)
      if (beat * U + k < n) d[k*ACC_W +: ACC_W] = acc(model_y(n, beat * U + k));
    return d;
  endfunction

  function automatic logic [U-1:0] exp_mask(input int n, input int beat);
    logic [U-1:0] m;
    m = '0;
    for (int k = 0; k < U; k++) m[k] = (beat * U + k < n);
    return m;
  endfunction

  function automatic logic [ACC_W-1:0] lane_of(input logic [DW-1:0] d, input int k);
    return d[k*ACC_W +: ACC_W];
  endfunction

  task automatic set_band(input int lo, input int dg, input int hi);
    for (int r = 0; r < NB; r++) begin
      m_arr[r][0] = lo; m_arr[r][1] = dg; m_arr[r][2] = hi;
    end
  endtask

  task automatic pack_inputs();
    int t;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < BND; c++) begin
        t = m_arr[r][c];
        if (r < NA) a_mat[(r*BND+c)*W +: W] = t[W-1:0];
        b_mat[(r*BND+c)*W +: W] = t[W-1:0];
      end
      t = x_arr[r];
      if (r < NA) a_vec[r*W +: W] = t[W-1:0];
      b_vec[r*W +: W] = t[W-1:0];
    end
  endtask

  // ---------------- compare process for the 5-row engine ----------------
  bit            cmp_en = 1'b0;
  int            exp_beat;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [U-1:0]  prev_mask;
  logic          prev_last;
  logic [DW-1:0] cap [GA];

  always @(negedge clk) begin
    if (cmp_en) begin
      if (a_valid) begin
        if (exp_beat >= GA) check("extra_beat", 1, 0);
        else begin
          check("beat_data", a_data, exp_data(NA, exp_beat));
          check("beat_mask", a_mask, exp_mask(NA, exp_beat));
          check("beat_last", a_last, (exp_beat == GA - 1));
        end
        if (prev_stall) begin
          check("hold_data", a_data, prev_data);
          check("hold_mask", a_mask, prev_mask);
          check("hold_last", a_last, prev_last);
        end
        if (a_ready) begin
          if (exp_beat < GA) cap[exp_beat] = a_data;
          exp_beat++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = a_data;
          prev_mask  = a_mask;
          prev_last  = a_last;
        end
      end else begin
        if (prev_stall) check("valid_dropped_without_handshake", 0, 1);
        prev_stall = 1'b0;
      end
      if (a_done) check("done_after_last_beat", exp_beat, GA);
    end
  end

  // ---------------- run drivers ----------------
  task automatic run_a(input int stall, input int exp_first, input int exp_done, input bit poke);
    int cyc, first, nvalid;
    bit got_done;
    pack_inputs();
    exp_beat   = 0;
    prev_stall = 1'b0;
    cmp_en     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b1;
    a_ready = (stall == 0);
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    first    = -1;
    nvalid   = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) start = (cyc == 3);
      if (a_valid && first < 0) first = cyc;
      if (a_valid && !a_ready) begin
        nvalid++;
        if (nvalid > stall) a_ready = 1'b1;
      end
      got_done = a_done;
    end
    check("done_seen", got_done, 1);
    if (exp_first >= 0) check("first_valid_latency", first, exp_first);
    if (exp_done >= 0) check("done_latency", cyc, exp_done);
    @(posedge clk); #1;
    check("done_one_cycle", a_done, 0);
    check("idle_after_done", a_busy, 0);
    cmp_en  = 1'b0;
    a_ready = 1'b0;
    start   = 1'b0;
  endtask

  task automatic run_b();
    int cyc, first, beats;
    bit got_done;
    pack_inputs();
    @(posedge clk); #1;
    b_start = 1'b1;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_start  = 1'b0;
    cyc      = 0;
    first    = -1;
    beats    = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (b_valid) begin
        if (first < 0) first = cyc;
        if (beats < 2) begin
          check("b_data", b_data, exp_data(NB, beats));
          check("b_mask", b_mask, 4'b1111);
          check("b_last", b_last, (beats == 1));
          if (beats == 1) check("b_lit_y7", lane_of(b_data, 3), acc(23));
        end
        beats++;
      end
      got_done = b_done;
    end
    check("b_beats", beats, 2);
    check("b_first_valid_latency", first, 2);
    check("b_done_latency", cyc, 6);
    b_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit saw_done;
    int waited;
    reset = 1'b1; start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    a_mat = '0; a_vec = '0; b_mat = '0; b_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_last", a_last, 0);
    check("rst_mask", a_mask, 0);
    check("rst_data", a_data, 0);
    reset = 1'b0;

    // Diagonal scale: y = 2*x.
    set_band(0, 2, 0);
    for (int r = 0; r < NB; r++) x_arr[r] = r + 1;
    run_a(0, 2, 6, 1'b0);
    check("diag_b0_l0", lane_of(cap[0], 0), acc(2));
    check("diag_b0_l3", lane_of(cap[0], 3), acc(8));
    check("diag_b1_l0", lane_of(cap[1], 0), acc(10));
    check("diag_b1_l1", lane_of(cap[1], 1), acc(0));

    // Boundary masking: corner 99s must never contribute.
    set_band(-1, 2, -1);
    m_arr[0][0] = 99;
    m_arr[4][2] = 99;
    for (int r = 0; r < NB; r++) x_arr[r] = 1;
    check("model_y0", model_y(NA, 0), 1);
    check("model_y2", model_y(NA, 2), 0);
    run_a(0, 2, 6, 1'b0);
    check("corner_b0_l0", lane_of(cap[0], 0), acc(1));
    check("corner_b0_l1", lane_of(cap[0], 1), acc(0));
    check("corner_b1_l0", lane_of(cap[1], 0), acc(1));

    // Backpressure on beat 0 with the same matrix and a ramp vector.
    for (int r = 0; r < NB; r++) x_arr[r] = r + 1;
    run_a(5, 2, -1, 1'b0);

    // Signed extremes.
    set_band(0, -32768, 0);
    for (int r = 0; r < NB; r++) x_arr[r] = -32768;
    run_a(0, 2, 6, 1'b0);
    check("ext_b0_l2", lane_of(cap[0], 2), acc(64'sd1073741824));
    check("ext_b1_l0", lane_of(cap[1], 0), acc(64'sd1073741824));
    set_band(0, -3, 0);
    for (int r = 0; r < NB; r++) x_arr[r] = -7;
    run_a(0, 2, 6, 1'b0);
    check("neg_b0_l1", lane_of(cap[0], 1), acc(21));

    // start pulsed while busy is ignored: still exactly two beats.
    set_band(1, 3, -2);
    for (int r = 0; r < NB; r++) x_arr[r] = 5 - 2 * r;
    run_a(0, 2, 6, 1'b1);

    // Reset during OUT clears everything and suppresses done.
    pack_inputs();
    @(posedge clk); #1;
    start   = 1'b1;
    a_ready = 1'b0;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (!a_valid && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reach_out_before_reset", a_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", a_valid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_data", a_data, 0);
    check("midrst_mask", a_mask, 0);
    @(posedge clk); #1;
    reset    = 1'b0;
    a_ready  = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_done || a_valid) saw_done = 1'b1;
    end
    check("no_activity_after_reset", saw_done, 0);
    a_ready = 1'b0;
    run_a(0, 2, 6, 1'b0);

    // Exact multiple: eight rows on four lanes.
    set_band(1, 2, 1);
    for (int r = 0; r < NB; r++) x_arr[r] = r + 1;
    check("model_b_y7", model_y(NB, 7), 23);
    run_b();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
